// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined carry-select adder/subtractor: slice and block
// sizing, configuration legality and the add/sub operation encoding.
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_w(input int width, input int stages);
        return (stages > 32'sd0) ? (width / stages) : width;
    endfunction

    function automatic int nblk(input int sw, input int blk);
        return (blk > 32'sd0) ? (sw / blk) : 32'sd0;
    endfunction

    // Every slice must be cut into whole carry-select blocks.
    function automatic bit cfg_legal(input int width, input int stages, input int blk);
        if ((stages < 32'sd1) || (stages > 32'sd8) || (blk < 32'sd1) || (width < 32'sd1)) begin
            return 1'b0;
        end else begin
            return ((width % stages) == 32'sd0) && (((width / stages) % blk) == 32'sd0);
        end
    endfunction

endpackage

// File: rtl/pipe_csel_addsub_csel_block.sv
// One BLK-bit carry-select block: both carry-in outcomes are precomputed and the
// real carry-in picks one.
module csel_block
    import pipe_adder_pkg::*;
#(
    parameter int BLK = 5
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK:0] res0_s;
    logic [BLK:0] res1_s;

    assign res0_s      = {1'b0, a} + {1'b0, b};
    assign res1_s      = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    assign {cout, sum} = cin ? res1_s : res0_s;

endmodule

// File: rtl/pipe_csel_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready back-pressure; slice k is
// added in stage k. Optional output saturation on signed overflow: PIPE_CSEL_SAT_EN.
module pipe_csel_addsub
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int STAGES = 2,
    parameter int BLK    = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int SLICE_W = slice_w(WIDTH, STAGES);
    localparam int NBLK    = nblk(SLICE_W, BLK);
    localparam int LAST    = STAGES - 1;

    if (!cfg_legal(WIDTH, STAGES, BLK)) begin : g_bad_cfg
        $error("pipe_csel_addsub: illegal WIDTH/STAGES/BLK combination");
    end

    logic                          advance_s;
    logic [STAGES-1:0]             valid_r;
    logic [STAGES-1:0]             sub_r;
    logic [STAGES-1:0]             carry_r;
    logic [STAGES-1:0][WIDTH-1:0]  a_r;
    logic [STAGES-1:0][WIDTH-1:0]  b_r;
    logic [STAGES-1:0][WIDTH-1:0]  res_r;
    logic                          ovf_r;

    logic [STAGES-1:0]             st_valid_s;
    logic [STAGES-1:0]             st_sub_s;
    logic [STAGES-1:0]             st_c_s;
    logic [STAGES-1:0]             sl_cout_s;
    logic [STAGES-1:0][WIDTH-1:0]  st_a_s;
    logic [STAGES-1:0][WIDTH-1:0]  st_b_s;
    logic [STAGES-1:0][WIDTH-1:0]  st_res_s;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_res_s;
    logic                          ovf_s;
    logic [WIDTH-1:0]              fin_res_s;
    logic                          unused_s;

    assign advance_s = !valid_r[LAST] || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = valid_r[LAST];
    assign sum       = {carry_r[LAST], res_r[LAST]};
    assign ovf       = ovf_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Stage 0 sees the raw operands (B already inverted for subtract);
        // later stages see the skewed operands and the registered carry.
        if (k == 0) begin : g_head
            assign st_valid_s[k] = in_valid;
            assign st_sub_s[k]   = in_sub;
            assign st_a_s[k]     = a;
            assign st_b_s[k]     = (in_sub == OP_SUB) ? ~b : b;
            assign st_c_s[k]     = (in_sub == OP_SUB) ? ~cin : cin;
            assign st_res_s[k]   = {WIDTH{1'b0}};
        end else begin : g_tail
            assign st_valid_s[k] = valid_r[k-1];
            assign st_sub_s[k]   = sub_r[k-1];
            assign st_a_s[k]     = a_r[k-1];
            assign st_b_s[k]     = b_r[k-1];
            assign st_c_s[k]     = carry_r[k-1];
            assign st_res_s[k]   = res_r[k-1];
        end

        logic [SLICE_W-1:0] blk_sum_s;
        logic [WIDTH-1:0]   merged_s;

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            logic cin_s;
            logic cout_s;
            if (j == 0) begin : g_first
                assign cin_s = st_c_s[k];
            end else begin : g_next
                assign cin_s = g_blk[j-1].cout_s;
            end
            csel_block #(.BLK(BLK)) u_blk (
                .a    (st_a_s[k][k*SLICE_W + j*BLK +: BLK]),
                .b    (st_b_s[k][k*SLICE_W + j*BLK +: BLK]),
                .cin  (cin_s),
                .sum  (blk_sum_s[j*BLK +: BLK]),
                .cout (cout_s)
            );
        end

        assign sl_cout_s[k] = g_blk[NBLK-1].cout_s;

        // Drop this stage's slice into the partially completed result word.
        always_comb begin
            merged_s                         = st_res_s[k];
            merged_s[k*SLICE_W +: SLICE_W]   = blk_sum_s;
        end

        assign nxt_res_s[k] = merged_s;
    end

    assign ovf_s = (st_a_s[LAST][WIDTH-1] == st_b_s[LAST][WIDTH-1]) &&
                   (nxt_res_s[LAST][WIDTH-1] != st_a_s[LAST][WIDTH-1]);

`ifdef PIPE_CSEL_SAT_EN
    // Clamp toward the sign of the operands: positive overflow only happens when A is non-negative.
    always_comb begin
        if (ovf_s) begin
            fin_res_s = st_a_s[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            fin_res_s = nxt_res_s[LAST];
        end
    end
`else
    assign fin_res_s = nxt_res_s[LAST];
`endif

    // Pipeline registers: everything holds while the output is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= {STAGES{1'b0}};
            sub_r   <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            a_r     <= {(STAGES*WIDTH){1'b0}};
            b_r     <= {(STAGES*WIDTH){1'b0}};
            res_r   <= {(STAGES*WIDTH){1'b0}};
            ovf_r   <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= st_valid_s[k];
                if (st_valid_s[k]) begin
                    sub_r[k]   <= st_sub_s[k];
                    carry_r[k] <= sl_cout_s[k];
                    a_r[k]     <= st_a_s[k];
                    b_r[k]     <= st_b_s[k];
                    res_r[k]   <= (k == LAST) ? fin_res_s : nxt_res_s[k];
                end
            end
            if (st_valid_s[LAST]) begin
                ovf_r <= ovf_s;
            end
        end
    end

    assign unused_s = ^{a_r, b_r, sub_r, st_a_s, st_b_s, st_sub_s};

endmodule
